// File: rtl/dma_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_seq_pkg
// Purpose  : Shared types and constants for the DMA channel sequencer.
//            - seqState_t : one-hot sequencer states (SI, S0, S1, S2, S4)
//            - chMode_t   : per-channel mode bits (autoinit, address direction)
//            - paramsOk() : legal-range check for the sequencer parameters
// Revision : 1.0 - initial release
// ============================================================================
package dma_seq_pkg;

    localparam int c_MIN_CH = 2;
    localparam int c_MAX_CH = 8;

    typedef enum logic [4:0] {
        SI = 5'b00001,  // idle
        S0 = 5'b00010,  // hold request
        S1 = 5'b00100,  // address strobe
        S2 = 5'b01000,  // transfer
        S4 = 5'b10000   // done / channel update
    } seqState_t;

    typedef struct packed {
        logic autoinit;  // reload from base on terminal count
        logic dec;       // 1 = decrement address, 0 = increment
    } chMode_t;

    function automatic bit paramsOk(input int numCh, input int addrW, input int countW);
        return (numCh >= c_MIN_CH) && (numCh <= c_MAX_CH) && (addrW >= 1) && (countW >= 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_channel_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_channel_sequencer_if
// Purpose  : Bundles the request, program-load and bus-strobe signals of the
//            DMA channel sequencer.
//            master : register file / request side (drives DREQ, HLDA, LOAD_*)
//            slave  : sequencer side (drives HRQ, DACK, AEN, ADSTB, ADDR, ...)
// Revision : 1.0 - initial release
// ============================================================================
interface dma_channel_sequencer_if #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 16,
    parameter int COUNT_W = 16
);
    logic [NUM_CH-1:0]         DREQ;
    logic                      HLDA;
    logic                      ROTATE;
    logic                      LOAD_EN;
    logic [$clog2(NUM_CH)-1:0] LOAD_CH;
    logic [ADDR_W-1:0]         LOAD_ADDR;
    logic [COUNT_W-1:0]        LOAD_COUNT;
    logic                      LOAD_AUTOINIT;
    logic                      LOAD_DEC;

    logic                      HRQ;
    logic [NUM_CH-1:0]         DACK;
    logic                      AEN;
    logic                      ADSTB;
    logic [ADDR_W-1:0]         ADDR;
    logic                      XFER;
    logic                      TC;
    logic [NUM_CH-1:0]         TC_STATUS;
    logic [NUM_CH-1:0]         MASK;

    modport master (
        output DREQ, HLDA, ROTATE, LOAD_EN, LOAD_CH, LOAD_ADDR, LOAD_COUNT,
               LOAD_AUTOINIT, LOAD_DEC,
        input  HRQ, DACK, AEN, ADSTB, ADDR, XFER, TC, TC_STATUS, MASK
    );

    modport slave (
        input  DREQ, HLDA, ROTATE, LOAD_EN, LOAD_CH, LOAD_ADDR, LOAD_COUNT,
               LOAD_AUTOINIT, LOAD_DEC,
        output HRQ, DACK, AEN, ADSTB, ADDR, XFER, TC, TC_STATUS, MASK
    );
endinterface
`default_nettype wire

// File: rtl/dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dma_priority_arbiter
// Purpose  : Fixed (ch0 highest) or rotating priority grant over NUM_CH
//            requests. The priority pointer names the highest-priority
//            channel in rotating mode and advances past each serviced channel.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_req           - effective (unmasked) requests
//            i_rotate        - 1 = rotating, 0 = fixed priority
//            i_advance       - a channel completed service this cycle
//            i_servedCh      - index of the completed channel
//            o_grantValid    - any request present
//            o_grantCh       - index of the winning channel
// Revision : 1.0 - initial release
// ============================================================================
module dma_priority_arbiter #(
    parameter int NUM_CH = 4
) (
    input  wire                        clk,
    input  wire                        rst,
    input  wire [NUM_CH-1:0]           i_req,
    input  wire                        i_rotate,
    input  wire                        i_advance,
    input  wire [$clog2(NUM_CH)-1:0]   i_servedCh,
    output logic                       o_grantValid,
    output logic [$clog2(NUM_CH)-1:0]  o_grantCh
);
    localparam int c_CH_W = $clog2(NUM_CH);

    logic [c_CH_W-1:0] r_prioPtr;
    logic [c_CH_W-1:0] w_base;
    logic [NUM_CH-1:0] w_reqRot;
    logic [c_CH_W-1:0] w_enc;
    logic [c_CH_W:0]   w_sum;
    logic [c_CH_W:0]   w_grant;

    // Rotate the request vector so the highest-priority channel sits at bit 0,
    // pick the lowest set bit, then map the index back (mod NUM_CH).
    always_comb begin
        w_base   = i_rotate ? r_prioPtr : '0;
        w_reqRot = NUM_CH'({i_req, i_req} >> w_base);
        w_enc    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_reqRot[i]) begin
                w_enc = c_CH_W'(i);
            end
        end
        w_sum   = {1'b0, w_enc} + {1'b0, w_base};
        w_grant = (w_sum >= (c_CH_W + 1)'(NUM_CH)) ? (w_sum - (c_CH_W + 1)'(NUM_CH)) : w_sum;
    end

    assign o_grantValid = |i_req;
    assign o_grantCh    = w_grant[c_CH_W-1:0];

    // The serviced channel drops to lowest priority; its successor becomes highest.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prioPtr <= '0;
        end else if (i_advance) begin
            r_prioPtr <= (i_servedCh == c_CH_W'(NUM_CH - 1)) ? '0 : i_servedCh + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/dma_channel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dma_channel_sequencer
// Purpose  : Single-transfer DMA sequencer for NUM_CH channels. Runs the
//            SI -> S0 -> S1 -> S2 -> S4 cycle, holds per-channel base/current
//            address and count, mode bits, terminal-count status and masks.
// Ports    : CLK, RESET - clock, synchronous active-high reset
//            bus        - slave modport of dma_channel_sequencer_if:
//                         in : DREQ, HLDA, ROTATE, LOAD_* program interface
//                         out: HRQ, DACK, AEN, ADSTB, ADDR, XFER, TC,
//                              TC_STATUS, MASK
// Revision : 1.0 - initial release
// ============================================================================
module dma_channel_sequencer
    import dma_seq_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 16,
    parameter int COUNT_W = 16
) (
    input wire                      CLK,
    input wire                      RESET,
    dma_channel_sequencer_if.slave  bus
);
    localparam int c_CH_W = $clog2(NUM_CH);

    seqState_t          r_state;
    seqState_t          w_nextState;
    logic [c_CH_W-1:0]  r_ch;

    logic [ADDR_W-1:0]  r_baseAddr  [NUM_CH];
    logic [ADDR_W-1:0]  r_curAddr   [NUM_CH];
    logic [COUNT_W-1:0] r_baseCount [NUM_CH];
    logic [COUNT_W-1:0] r_curCount  [NUM_CH];
    chMode_t            r_mode      [NUM_CH];
    logic [NUM_CH-1:0]  r_mask;
    logic [NUM_CH-1:0]  r_tcStatus;

    logic [NUM_CH-1:0]  w_effReq;
    logic               w_grantValid;
    logic [c_CH_W-1:0]  w_grantCh;
    logic               w_update;
    logic               w_lastXfer;
    logic               w_hrq, w_aen, w_adstb, w_xfer, w_tc, w_active;

    assign w_effReq   = bus.DREQ & ~r_mask;
    assign w_lastXfer = (r_curCount[r_ch] == '0);
    // Channel update only happens when the done cycle completes with HLDA held.
    assign w_update   = (r_state == S4) && bus.HLDA;

    dma_priority_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk          (CLK),
        .rst          (RESET),
        .i_req        (w_effReq),
        .i_rotate     (bus.ROTATE),
        .i_advance    (w_update),
        .i_servedCh   (r_ch),
        .o_grantValid (w_grantValid),
        .o_grantCh    (w_grantCh)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= SI;
            r_ch    <= '0;
        end else begin
            r_state <= w_nextState;
            if ((r_state == SI) && w_grantValid) begin
                r_ch <= w_grantCh;
            end
        end
    end

    // Next state and strobes; losing HLDA after S0 abandons the cycle.
    always_comb begin
        w_nextState = r_state;
        w_hrq       = 1'b0;
        w_aen       = 1'b0;
        w_adstb     = 1'b0;
        w_xfer      = 1'b0;
        w_tc        = 1'b0;
        w_active    = 1'b0;
        case (r_state)
            SI: begin
                if (w_grantValid) begin
                    w_nextState = S0;
                end
            end
            S0: begin
                w_hrq = 1'b1;
                if (bus.HLDA) begin
                    w_nextState = S1;
                end
            end
            S1: begin
                w_hrq       = 1'b1;
                w_aen       = 1'b1;
                w_adstb     = 1'b1;
                w_active    = 1'b1;
                w_nextState = bus.HLDA ? S2 : SI;
            end
            S2: begin
                w_hrq       = 1'b1;
                w_aen       = 1'b1;
                w_xfer      = 1'b1;
                w_active    = 1'b1;
                w_nextState = bus.HLDA ? S4 : SI;
            end
            S4: begin
                w_hrq       = 1'b1;
                w_aen       = 1'b1;
                w_active    = 1'b1;
                w_tc        = bus.HLDA && w_lastXfer;
                w_nextState = SI;
            end
            default: begin
                w_nextState = SI;
            end
        endcase
    end

    assign bus.HRQ       = w_hrq;
    assign bus.AEN       = w_aen;
    assign bus.ADSTB     = w_adstb;
    assign bus.XFER      = w_xfer;
    assign bus.TC        = w_tc;
    assign bus.DACK      = w_active ? ({{(NUM_CH - 1){1'b0}}, 1'b1} << r_ch) : '0;
    assign bus.ADDR      = w_active ? r_curAddr[r_ch] : '0;
    assign bus.MASK      = r_mask;
    assign bus.TC_STATUS = r_tcStatus;

    // A program load to a channel overrides that channel's update in the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_baseAddr[i]  <= '0;
                r_curAddr[i]   <= '0;
                r_baseCount[i] <= '0;
                r_curCount[i]  <= '0;
                r_mode[i]      <= '0;
            end
            r_mask     <= '0;
            r_tcStatus <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.LOAD_EN && (bus.LOAD_CH == c_CH_W'(i))) begin
                    r_baseAddr[i]  <= bus.LOAD_ADDR;
                    r_curAddr[i]   <= bus.LOAD_ADDR;
                    r_baseCount[i] <= bus.LOAD_COUNT;
                    r_curCount[i]  <= bus.LOAD_COUNT;
                    r_mode[i]      <= '{autoinit: bus.LOAD_AUTOINIT, dec: bus.LOAD_DEC};
                    r_mask[i]      <= 1'b0;
                    r_tcStatus[i]  <= 1'b0;
                end else if (w_update && (r_ch == c_CH_W'(i))) begin
                    if (r_curCount[i] == '0) begin
                        r_tcStatus[i] <= 1'b1;
                        if (r_mode[i].autoinit) begin
                            r_curAddr[i]  <= r_baseAddr[i];
                            r_curCount[i] <= r_baseCount[i];
                        end else begin
                            r_mask[i] <= 1'b1;
                        end
                    end else begin
                        r_curCount[i] <= r_curCount[i] - 1'b1;
                        r_curAddr[i]  <= r_mode[i].dec ? (r_curAddr[i] - 1'b1)
                                                       : (r_curAddr[i] + 1'b1);
                    end
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dma_channel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_channel_sequencer
// Purpose  : Directed self-checking bench for dma_channel_sequencer
//            (4 channels, 16-bit address and count).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_channel_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    dma_channel_sequencer_if bus ();

    dma_channel_sequencer dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ctrl();
        return {bus.HRQ, bus.AEN, bus.ADSTB, bus.XFER, bus.TC};
    endfunction

    task automatic loadCh(input logic [1:0] ch, input logic [15:0] addr, input logic [15:0] cnt,
                          input logic ai, input logic dec);
        bus.LOAD_EN       = 1'b1;
        bus.LOAD_CH       = ch;
        bus.LOAD_ADDR     = addr;
        bus.LOAD_COUNT    = cnt;
        bus.LOAD_AUTOINIT = ai;
        bus.LOAD_DEC      = dec;
        tick();
        bus.LOAD_EN       = 1'b0;
    endtask

    // One complete transfer from SI with HLDA high; control bits are {HRQ,AEN,ADSTB,XFER,TC}.
    task automatic runXfer(input string tag, input logic [3:0] dack, input logic [15:0] addr,
                           input logic tc);
        tick(); chk({tag, ":S0ctl"}, ctrl(), 5'b10000);
        tick(); chk({tag, ":S1ctl"}, ctrl(), 5'b11100);
                chk({tag, ":S1dack"}, bus.DACK, dack);
                chk({tag, ":S1addr"}, bus.ADDR, addr);
        tick(); chk({tag, ":S2ctl"}, ctrl(), 5'b11010);
                chk({tag, ":S2dack"}, bus.DACK, dack);
        tick(); chk({tag, ":S4ctl"}, ctrl(), {4'b1100, tc});
                chk({tag, ":S4dack"}, bus.DACK, dack);
        tick(); chk({tag, ":SIctl"}, ctrl(), 5'b00000);
    endtask

    initial begin
        bus.DREQ = '0; bus.HLDA = 1'b0; bus.ROTATE = 1'b0;
        bus.LOAD_EN = 1'b0; bus.LOAD_CH = '0; bus.LOAD_ADDR = '0; bus.LOAD_COUNT = '0;
        bus.LOAD_AUTOINIT = 1'b0; bus.LOAD_DEC = 1'b0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_ctl", ctrl(), 5'b00000);
        chk("rst_dack", bus.DACK, 4'b0000);
        chk("rst_addr", bus.ADDR, 16'h0000);
        chk("rst_mask", bus.MASK, 4'b0000);
        chk("rst_tcs", bus.TC_STATUS, 4'b0000);

        // Program channels
        loadCh(2'd0, 16'h0100, 16'd10, 1'b0, 1'b0);
        loadCh(2'd1, 16'h0200, 16'd10, 1'b0, 1'b0);
        loadCh(2'd2, 16'h1000, 16'd2,  1'b0, 1'b0);
        loadCh(2'd3, 16'h3000, 16'd10, 1'b0, 1'b0);

        // Fixed priority
        bus.HLDA = 1'b1; bus.ROTATE = 1'b0;
        bus.DREQ = 4'b0011; runXfer("fix0", 4'b0001, 16'h0100, 1'b0);
        bus.DREQ = 4'b1110; runXfer("fix1", 4'b0010, 16'h0200, 1'b0);

        // Rotating priority (pointer sits after ch1)
        bus.ROTATE = 1'b1; bus.DREQ = 4'b0011;
        runXfer("rot0", 4'b0001, 16'h0101, 1'b0);
        runXfer("rot1", 4'b0010, 16'h0201, 1'b0);
        runXfer("rot2", 4'b0001, 16'h0102, 1'b0);

        // Terminal count without autoinit
        bus.ROTATE = 1'b0; bus.DREQ = 4'b0100;
        runXfer("tc0", 4'b0100, 16'h1000, 1'b0);
        runXfer("tc1", 4'b0100, 16'h1001, 1'b0);
        runXfer("tc2", 4'b0100, 16'h1002, 1'b1);
        chk("tc_mask", bus.MASK, 4'b0100);
        chk("tc_tcs", bus.TC_STATUS, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("tc_masked_idle", {bus.HRQ, bus.DACK}, 5'b00000);
        end

        // Autoinit with decrement
        bus.DREQ = '0;
        loadCh(2'd1, 16'h0000, 16'd0, 1'b1, 1'b1);
        bus.DREQ = 4'b0010;
        runXfer("ai0", 4'b0010, 16'h0000, 1'b1);
        runXfer("ai1", 4'b0010, 16'h0000, 1'b1);
        chk("ai_mask", bus.MASK, 4'b0100);
        chk("ai_tcs", bus.TC_STATUS, 4'b0110);

        // Address wrap on decrement
        bus.DREQ = '0;
        loadCh(2'd1, 16'h0000, 16'd1, 1'b0, 1'b1);
        chk("wrap_tcs_cleared", bus.TC_STATUS, 4'b0100);
        bus.DREQ = 4'b0010;
        runXfer("wrap0", 4'b0010, 16'h0000, 1'b0);
        runXfer("wrap1", 4'b0010, 16'hFFFF, 1'b1);
        chk("wrap_mask", bus.MASK, 4'b0110);

        // HLDA handshake: wait in S0, then abort in S2
        bus.DREQ = 4'b1000; bus.HLDA = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hl_wait", {bus.HRQ, bus.AEN, bus.DACK}, 6'b100000);
        end
        bus.HLDA = 1'b1;
        tick(); chk("hl_S1ctl", ctrl(), 5'b11100);
                chk("hl_S1addr", bus.ADDR, 16'h3000);
        tick(); chk("hl_S2ctl", ctrl(), 5'b11010);
        bus.HLDA = 1'b0;
        tick(); chk("hl_abort", {ctrl(), bus.DACK}, 9'h000);
        bus.HLDA = 1'b1;
        runXfer("hl_retry", 4'b1000, 16'h3000, 1'b0);

        // Reset in S2
        tick(); tick(); tick();
        chk("rs_S2ctl", ctrl(), 5'b11010);
        rst = 1'b1;
        tick();
        chk("rs_ctl", ctrl(), 5'b00000);
        chk("rs_dack_addr", {bus.DACK, bus.ADDR}, 20'h00000);
        chk("rs_mask_tcs", {bus.MASK, bus.TC_STATUS}, 8'h00);
        rst = 1'b0; bus.DREQ = '0;
        tick();
        chk("rs_idle", ctrl(), 5'b00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
